// File: rtl/mario_anim_ctrl.sv
// Mario sprite animation sequencer: turns per-frame motion status into the
// registered 4-bit sprite-ROM select code, pacing walk/climb/death frames.
module mario_anim_ctrl #(
  parameter int unsigned WALK_DIV  = 6,
  parameter int unsigned CLIMB_DIV = 8,
  parameter int unsigned DIE_DIV   = 10,
  parameter int unsigned DIE_SPIN  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       airborne,
  input  logic       climbing,
  input  logic       climb_move,
  input  logic       die,
  output logic [3:0] animate_state,
  output logic       anim_done
);

  localparam int unsigned MAX_WC  = (WALK_DIV > CLIMB_DIV) ? WALK_DIV : CLIMB_DIV;
  localparam int unsigned MAX_DIV = (MAX_WC > DIE_DIV) ? MAX_WC : DIE_DIV;
  localparam int unsigned DIV_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int unsigned SPIN_LAST = DIE_SPIN * 3;
  localparam int unsigned SPIN_W  = $clog2(SPIN_LAST + 1);

  localparam logic [3:0] STAND       = 4'b0000;
  localparam logic [3:0] WALK_LEFT1  = 4'b0001;
  localparam logic [3:0] WALK_LEFT2  = 4'b0010;
  localparam logic [3:0] WALK_MID    = 4'b0011;
  localparam logic [3:0] WALK_RIGHT1 = 4'b0100;
  localparam logic [3:0] WALK_RIGHT2 = 4'b0101;
  localparam logic [3:0] FLY_LEFT    = 4'b0110;
  localparam logic [3:0] FLY_RIGHT   = 4'b0111;
  localparam logic [3:0] CLAMP1      = 4'b1000;
  localparam logic [3:0] CLAMP2      = 4'b1001;
  localparam logic [3:0] DIE1        = 4'b1010;
  localparam logic [3:0] DIE4        = 4'b1101;

  typedef enum logic [2:0] {
    M_STAND = 3'd0,
    M_WALK  = 3'd1,
    M_AIR   = 3'd2,
    M_CLIMB = 3'd3,
    M_DEAD  = 3'd4
  } mode_t;

  mode_t             mode_q, mode_d;
  logic              left_q, left_d;
  logic [DIV_W-1:0]  div_q, div_d, div_lim;
  logic [1:0]        phase_q, phase_d;
  logic [SPIN_W-1:0] spin_q, spin_d;
  logic [3:0]        state_d;
  logic              done_d;
  logic              adv;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= M_STAND;
      left_q        <= 1'b0;
      div_q         <= '0;
      phase_q       <= '0;
      spin_q        <= '0;
      animate_state <= STAND;
      anim_done     <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      left_q        <= left_d;
      div_q         <= div_d;
      phase_q       <= phase_d;
      spin_q        <= spin_d;
      animate_state <= state_d;
      anim_done     <= done_d;
    end
  end

  // Mode priority, facing, shared divider/phase sequencing and sprite decode
  always_comb begin
    mode_d  = mode_q;
    left_d  = left_q;
    div_d   = div_q;
    phase_d = phase_q;
    spin_d  = spin_q;
    div_lim = DIV_W'(WALK_DIV - 1);
    adv     = 1'b0;
    state_d = STAND;
    done_d  = 1'b0;

    if (mode_q == M_DEAD || die)        mode_d = M_DEAD;
    else if (climbing)                  mode_d = M_CLIMB;
    else if (airborne)                  mode_d = M_AIR;
    else if (move_left ^ move_right)    mode_d = M_WALK;
    else                                mode_d = M_STAND;

    if (mode_d != M_DEAD && (move_left ^ move_right)) left_d = move_left;

    case (mode_q)
      M_WALK: begin
        adv     = frame_tick;
        div_lim = DIV_W'(WALK_DIV - 1);
      end
      M_CLIMB: begin
        adv     = frame_tick & climb_move;
        div_lim = DIV_W'(CLIMB_DIV - 1);
      end
      M_DEAD: begin
        adv     = frame_tick && (spin_q != SPIN_W'(SPIN_LAST));
        div_lim = DIV_W'(DIE_DIV - 1);
      end
      default: adv = 1'b0;
    endcase

    // Any mode change, or a turn while walking, restarts the sequence; a
    // tick landing on that same edge is dropped.
    if (mode_d != mode_q || (mode_q == M_WALK && left_d != left_q)) begin
      div_d   = '0;
      phase_d = '0;
      spin_d  = '0;
    end else if (adv) begin
      if (div_q == div_lim) begin
        div_d = '0;
        case (mode_q)
          M_CLIMB: phase_d = {1'b0, ~phase_q[0]};
          M_DEAD: begin
            spin_d  = spin_q + SPIN_W'(1);
            phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
          end
          default: phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        endcase
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (mode_q)
      M_WALK: begin
        case (phase_q)
          2'd0:    state_d = left_q ? WALK_LEFT1 : WALK_RIGHT1;
          2'd1:    state_d = left_q ? WALK_LEFT2 : WALK_RIGHT2;
          default: state_d = WALK_MID;
        endcase
      end
      M_AIR:   state_d = left_q ? FLY_LEFT : FLY_RIGHT;
      M_CLIMB: state_d = phase_q[0] ? CLAMP2 : CLAMP1;
      M_DEAD: begin
        if (spin_q == SPIN_W'(SPIN_LAST)) begin
          state_d = DIE4;
          done_d  = 1'b1;
        end else begin
          state_d = DIE1 + {2'b00, phase_q};
        end
      end
      default: state_d = STAND;
    endcase
  end

endmodule
